// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Bundles the MEM-stage slot, the data-memory read response and the
//   write-back/stall outputs of the MEM->WB stage.
//   master : pipeline/memory side (drives i_*, observes o_*)
//   slave  : mem_wb_stage (observes i_*, drives o_*)
//   i_mem_valid/reg_write/mem_read/funct3/rd/alu_result : retiring instruction
//   i_dmem_rvalid/rdata : word-aligned little-endian load response
//   o_stall : hold upstream stages; o_wb_* : register-file write port
//   o_load_misaligned : one-cycle pulse for a dropped misaligned load
interface mem_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            i_mem_valid;
  logic            i_mem_reg_write;
  logic            i_mem_mem_read;
  logic [2:0]      i_mem_funct3;
  logic [4:0]      i_mem_rd;
  logic [XLEN-1:0] i_mem_alu_result;
  logic            i_dmem_rvalid;
  logic [XLEN-1:0] i_dmem_rdata;
  logic            o_stall;
  logic            o_wb_reg_write;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic            o_load_misaligned;

  modport master (
    output i_mem_valid, i_mem_reg_write, i_mem_mem_read, i_mem_funct3,
           i_mem_rd, i_mem_alu_result, i_dmem_rvalid, i_dmem_rdata,
    input  o_stall, o_wb_reg_write, o_wb_rd, o_wb_data, o_load_misaligned
  );

  modport slave (
    input  i_mem_valid, i_mem_reg_write, i_mem_mem_read, i_mem_funct3,
           i_mem_rd, i_mem_alu_result, i_dmem_rvalid, i_dmem_rdata,
    output o_stall, o_wb_reg_write, o_wb_rd, o_wb_data, o_load_misaligned
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM->WB pipeline register of the RV32I core. Retires ALU results with one
//   cycle of latency, waits for the data-memory response on loads, aligns and
//   extends load data, and stalls upstream while a load response is pending.
//   i_clk : core clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : mem_wb_stage_if.slave (MEM slot, dmem response, WB outputs, stall)
//
//   state     | meaning
//   IDLE      | no load outstanding; MEM slot retires or launches a wait
//   WAIT_LOAD | load issued, response not yet seen; upstream held
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_wb_stage_if.slave bus
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t          r_state;
  logic [4:0]      r_ld_rd;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_addr;
  logic            r_ld_reg_write;
  logic            r_wb_reg_write;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_load_misaligned;

  logic            w_load_in_idle;
  logic [4:0]      w_ld_rd;
  logic [2:0]      w_ld_funct3;
  logic [1:0]      w_ld_addr;
  logic            w_ld_reg_write;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_aligned;
  logic            w_misaligned;

  assign w_load_in_idle = (r_state == IDLE) && bus.i_mem_valid && bus.i_mem_mem_read;

  // A zero-wait load aligns from the live slot; a delayed one from the capture.
  assign w_ld_rd        = (r_state == WAIT_LOAD) ? r_ld_rd        : bus.i_mem_rd;
  assign w_ld_funct3    = (r_state == WAIT_LOAD) ? r_ld_funct3    : bus.i_mem_funct3;
  assign w_ld_addr      = (r_state == WAIT_LOAD) ? r_ld_addr      : bus.i_mem_alu_result[1:0];
  assign w_ld_reg_write = (r_state == WAIT_LOAD) ? r_ld_reg_write : bus.i_mem_reg_write;

  // Move the addressed byte/halfword down to bit 0 before extending.
  assign w_shifted = bus.i_dmem_rdata >> {w_ld_addr, 3'b000};

  always_comb begin
    w_aligned    = w_shifted;
    w_misaligned = 1'b0;
    case (w_ld_funct3)
      3'b000: w_aligned = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100: w_aligned = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001: begin
        w_aligned    = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
        w_misaligned = w_ld_addr[0];
      end
      3'b101: begin
        w_aligned    = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
        w_misaligned = w_ld_addr[0];
      end
      // LW and the reserved encodings
      default: begin
        w_aligned    = bus.i_dmem_rdata;
        w_misaligned = (w_ld_addr != 2'b00);
      end
    endcase
  end

  assign bus.o_stall = ((r_state == WAIT_LOAD) || w_load_in_idle) && !bus.i_dmem_rvalid;

  assign bus.o_wb_reg_write    = r_wb_reg_write;
  assign bus.o_wb_rd           = r_wb_rd;
  assign bus.o_wb_data         = r_wb_data;
  assign bus.o_load_misaligned = r_load_misaligned;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state           <= IDLE;
      r_ld_rd           <= '0;
      r_ld_funct3       <= '0;
      r_ld_addr         <= '0;
      r_ld_reg_write    <= 1'b0;
      r_wb_reg_write    <= 1'b0;
      r_wb_rd           <= '0;
      r_wb_data         <= '0;
      r_load_misaligned <= 1'b0;
    end else begin
      // Every retire is a one-cycle event; anything else is a bubble.
      r_wb_reg_write    <= 1'b0;
      r_wb_rd           <= '0;
      r_wb_data         <= '0;
      r_load_misaligned <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_in_idle) begin
            if (bus.i_dmem_rvalid) begin
              r_wb_reg_write    <= w_ld_reg_write && (w_ld_rd != 5'd0) && !w_misaligned;
              r_wb_rd           <= w_ld_rd;
              r_wb_data         <= w_misaligned ? '0 : w_aligned;
              r_load_misaligned <= w_misaligned;
            end else begin
              r_state        <= WAIT_LOAD;
              r_ld_rd        <= bus.i_mem_rd;
              r_ld_funct3    <= bus.i_mem_funct3;
              r_ld_addr      <= bus.i_mem_alu_result[1:0];
              r_ld_reg_write <= bus.i_mem_reg_write;
            end
          end else if (bus.i_mem_valid) begin
            r_wb_reg_write <= bus.i_mem_reg_write && (bus.i_mem_rd != 5'd0);
            r_wb_rd        <= bus.i_mem_rd;
            r_wb_data      <= bus.i_mem_alu_result;
          end
        end
        WAIT_LOAD: begin
          if (bus.i_dmem_rvalid) begin
            r_state           <= IDLE;
            r_wb_reg_write    <= w_ld_reg_write && (w_ld_rd != 5'd0) && !w_misaligned;
            r_wb_rd           <= w_ld_rd;
            r_wb_data         <= w_misaligned ? '0 : w_aligned;
            r_load_misaligned <= w_misaligned;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  mem_wb_stage_if #(.XLEN(32)) bus ();

  mem_wb_stage #(.XLEN(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: "is a load pending?" plus what must retire next cycle.
  logic        m_pend = 1'b0;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_addr;
  logic        m_rw;
  logic        m_stall = 1'b0;
  logic        exp_ret = 1'b0;
  logic        exp_rw  = 1'b0;
  logic        exp_mis = 1'b0;
  logic [4:0]  exp_rd  = '0;
  logic [31:0] exp_data = '0;

  function automatic void load_value(input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] w, output logic mis,
                                     output logic [31:0] val);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    h   = {b[{a[1], 1'b1}], b[{a[1], 1'b0}]};
    mis = 1'b0;
    val = w;
    case (f3)
      3'd0: val = 32'($signed(b[a]));
      3'd4: val = {24'd0, b[a]};
      3'd1: begin mis = a[0]; val = 32'($signed(h)); end
      3'd5: begin mis = a[0]; val = {16'd0, h}; end
      default: mis = (a != 2'd0);
    endcase
    if (mis) val = 32'd0;
  endfunction

  task automatic retire_load(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                             input logic [1:0] a, input logic [31:0] w);
    logic        mis;
    logic [31:0] val;
    load_value(f3, a, w, mis, val);
    exp_ret  = 1'b1;
    exp_rd   = rd;
    exp_data = val;
    exp_mis  = mis;
    exp_rw   = rw && (rd != 5'd0) && !mis;
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      check("rst_reg_write", 32'(bus.o_wb_reg_write), 32'd0);
      check("rst_stall", 32'(bus.o_stall), 32'd0);
      check("rst_misaligned", 32'(bus.o_load_misaligned), 32'd0);
      check("rst_data", bus.o_wb_data, 32'd0);
      m_pend = 1'b0; m_stall = 1'b0;
      exp_ret = 1'b0; exp_rw = 1'b0; exp_mis = 1'b0;
    end else begin
      check("model_reg_write", 32'(bus.o_wb_reg_write), 32'(exp_rw));
      check("model_misaligned", 32'(bus.o_load_misaligned), 32'(exp_mis));
      if (exp_ret) begin
        check("model_rd", 32'(bus.o_wb_rd), 32'(exp_rd));
        check("model_data", bus.o_wb_data, exp_data);
      end
      exp_ret = 1'b0; exp_rw = 1'b0; exp_mis = 1'b0;
      if (m_pend) begin
        m_stall = !bus.i_dmem_rvalid;
        if (bus.i_dmem_rvalid) begin
          retire_load(m_rd, m_rw, m_f3, m_addr, bus.i_dmem_rdata);
          m_pend = 1'b0;
        end
      end else if (bus.i_mem_valid && bus.i_mem_mem_read) begin
        if (bus.i_dmem_rvalid) begin
          m_stall = 1'b0;
          retire_load(bus.i_mem_rd, bus.i_mem_reg_write, bus.i_mem_funct3,
                      bus.i_mem_alu_result[1:0], bus.i_dmem_rdata);
        end else begin
          m_stall = 1'b1;
          m_pend  = 1'b1;
          m_rd    = bus.i_mem_rd;
          m_rw    = bus.i_mem_reg_write;
          m_f3    = bus.i_mem_funct3;
          m_addr  = bus.i_mem_alu_result[1:0];
        end
      end else begin
        m_stall = 1'b0;
        if (bus.i_mem_valid) begin
          exp_ret  = 1'b1;
          exp_rd   = bus.i_mem_rd;
          exp_data = bus.i_mem_alu_result;
          exp_rw   = bus.i_mem_reg_write && (bus.i_mem_rd != 5'd0);
        end
      end
      check("model_stall", 32'(bus.o_stall), 32'(m_stall));
    end
  end

  task automatic drive(input logic v, input logic rw, input logic mr, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic rv, input logic [31:0] rdata);
    bus.i_mem_valid      = v;
    bus.i_mem_reg_write  = rw;
    bus.i_mem_mem_read   = mr;
    bus.i_mem_funct3     = f3;
    bus.i_mem_rd         = rd;
    bus.i_mem_alu_result = alu;
    bus.i_dmem_rvalid    = rv;
    bus.i_dmem_rdata     = rdata;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bubble();
    repeat (3) next_cycle();
    @(negedge i_clk);
    check("reset_wb_reg_write", 32'(bus.o_wb_reg_write), 32'd0);
    check("reset_stall", 32'(bus.o_stall), 32'd0);
    next_cycle();
    i_rst = 1'b0;

    // ALU retire
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd5, 32'h1234_5678, 1'b0, 32'd0);
    @(negedge i_clk);
    check("alu_no_stall", 32'(bus.o_stall), 32'd0);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("alu_reg_write", 32'(bus.o_wb_reg_write), 32'd1);
    check("alu_rd", 32'(bus.o_wb_rd), 32'd5);
    check("alu_data", bus.o_wb_data, 32'h1234_5678);

    // Zero-wait LB then LBU, back to back
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_1003, 1'b1, 32'h80FF_FFFF);
    @(negedge i_clk);
    check("lb_no_stall", 32'(bus.o_stall), 32'd0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 3'b100, 5'd8, 32'h0000_1003, 1'b1, 32'h80FF_FFFF);
    @(negedge i_clk);
    check("lb_data", bus.o_wb_data, 32'hFFFF_FF80);
    check("lb_reg_write", 32'(bus.o_wb_reg_write), 32'd1);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("lbu_data", bus.o_wb_data, 32'h0000_0080);
    check("lbu_rd", 32'(bus.o_wb_rd), 32'd8);

    // LH with a 3-cycle wait
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd9, 32'h0000_2002, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("lh_wait_stall", 32'(bus.o_stall), 32'd1);
      check("lh_wait_no_write", 32'(bus.o_wb_reg_write), 32'd0);
      next_cycle();
    end
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'h8001_0000;
    @(negedge i_clk);
    check("lh_resp_no_stall", 32'(bus.o_stall), 32'd0);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("lh_data", bus.o_wb_data, 32'hFFFF_8001);
    check("lh_reg_write", 32'(bus.o_wb_reg_write), 32'd1);
    check("lh_rd", 32'(bus.o_wb_rd), 32'd9);

    // Misaligned LW
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd11, 32'h0000_3001, 1'b1, 32'h1122_3344);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("mis_pulse", 32'(bus.o_load_misaligned), 32'd1);
    check("mis_no_write", 32'(bus.o_wb_reg_write), 32'd0);
    check("mis_data", bus.o_wb_data, 32'd0);
    next_cycle();
    @(negedge i_clk);
    check("mis_pulse_end", 32'(bus.o_load_misaligned), 32'd0);

    // Write to x0
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 32'hAAAA_5555, 1'b0, 32'd0);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("x0_no_write", 32'(bus.o_wb_reg_write), 32'd0);
    check("x0_data_driven", bus.o_wb_data, 32'hAAAA_5555);

    // Stray rvalid in IDLE
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    @(negedge i_clk);
    check("stray_no_stall", 32'(bus.o_stall), 32'd0);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("stray_no_write", 32'(bus.o_wb_reg_write), 32'd0);
    check("stray_no_mis", 32'(bus.o_load_misaligned), 32'd0);

    // Reset while waiting on a load, then a late response
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 3'b001, 5'd12, 32'h0000_4000, 1'b0, 32'd0);
    @(negedge i_clk);
    check("rstwait_stall", 32'(bus.o_stall), 32'd1);
    next_cycle();
    i_rst = 1'b1;
    bubble();
    @(negedge i_clk);
    check("rstwait_outputs", 32'(bus.o_wb_reg_write), 32'd0);
    check("rstwait_stall_clr", 32'(bus.o_stall), 32'd0);
    next_cycle();
    i_rst = 1'b0;
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'h1234_ABCD;
    @(negedge i_clk);
    check("late_resp_no_stall", 32'(bus.o_stall), 32'd0);
    next_cycle(); bubble();
    @(negedge i_clk);
    check("late_resp_no_write", 32'(bus.o_wb_reg_write), 32'd0);
    check("late_resp_data", bus.o_wb_data, 32'd0);

    // Randomized traffic; the slot is held while the model says stall
    for (int n = 0; n < 800; n++) begin
      next_cycle();
      if (!m_stall) begin
        bus.i_mem_valid      = ($urandom_range(0, 3) != 0);
        bus.i_mem_mem_read   = ($urandom_range(0, 1) != 0);
        bus.i_mem_reg_write  = ($urandom_range(0, 3) != 0);
        bus.i_mem_funct3     = 3'($urandom_range(0, 7));
        bus.i_mem_rd         = 5'($urandom_range(0, 31));
        bus.i_mem_alu_result = $urandom;
      end
      bus.i_dmem_rvalid = ($urandom_range(0, 2) == 0);
      bus.i_dmem_rdata  = $urandom;
    end
    next_cycle();
    bus.i_dmem_rvalid = 1'b1;
    next_cycle(); bubble();
    repeat (2) @(negedge i_clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
